inst_line_fetcher: RTL and testbench

Line-fill engine on the memory side of the instruction cache. It accepts a 256-bit line read request from the cache and performs eight sequential 32-bit reads on the word-wide system bus. It assembles the words into one line and returns it with a single-cycle acknowledge and a page-fault indication. Bus stalls are bounded by an optional timeout, which is reported as a fault.

---
 rtl/inst_line_fetcher.sv | 144 ++++++++++++++
 tb/tb_inst_line_fetcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_line_fetcher.sv
// Instruction-cache line-fill engine: turns one line request into LINE_WORDS sequential
// 32-bit bus reads and returns the assembled line with a one-cycle ack and fault flag.
module inst_line_fetcher #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr_i,
    input  logic                      rd_i,
    output logic [32*LINE_WORDS-1:0]  data_o,
    output logic                      ack_o,
    output logic                      hw_page_fault_o,
    output logic [31:0]               bus_addr_o,
    output logic                      bus_rd_o,
    input  logic [31:0]               bus_data_i,
    input  logic                      bus_ack_i,
    input  logic                      bus_page_fault_i
);

    localparam int unsigned     IdxW       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0]     OffMask    = 32'(LINE_WORDS * 4 - 1);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(LINE_WORDS - 1);
    localparam logic [31:0]     TimeoutCnt = 32'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    fault_q, fault_d;
    logic [31:0]             base_q, base_d;
    logic [32*LINE_WORDS-1:0] line_q, line_d;
    logic [31:0]             bus_addr_q, bus_addr_d;
    logic                    bus_rd_q, bus_rd_d;
    logic                    ack_q, ack_d;
    logic                    pf_q, pf_d;
    logic                    timed_out;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        base_d     = base_q;
        line_d     = line_q;
        bus_addr_d = bus_addr_q;
        bus_rd_d   = bus_rd_q;
        ack_d      = 1'b0;
        pf_d       = 1'b0;
        timed_out  = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

        unique case (state_q)
            StIdle: begin
                if (rd_i) begin
                    base_d     = addr_i & ~OffMask;
                    idx_d      = '0;
                    cnt_d      = '0;
                    fault_d    = 1'b0;
                    line_d     = '0;
                    bus_addr_d = addr_i & ~OffMask;
                    bus_rd_d   = 1'b1;
                    state_d    = StRead;
                end
            end
            StRead: begin
                // Timeout wins over a same-cycle ack; the beat is abandoned from here on.
                if (timed_out) begin
                    bus_rd_d = 1'b0;
                    fault_d  = 1'b1;
                    if (rd_i) begin
                        state_d = StDone;
                        ack_d   = 1'b1;
                        pf_d    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus_ack_i) begin
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            line_d[32*k +: 32] = bus_data_i;
                        end
                    end
                    if (!rd_i) begin
                        bus_rd_d = 1'b0;
                        state_d  = StIdle;
                    end else if (bus_page_fault_i || (idx_q == LastIdx)) begin
                        bus_rd_d = 1'b0;
                        fault_d  = bus_page_fault_i;
                        state_d  = StDone;
                        ack_d    = 1'b1;
                        pf_d     = bus_page_fault_i;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        bus_addr_d = base_q + ((32'(idx_q) + 32'd1) << 2);
                        cnt_d      = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            base_q     <= '0;
            line_q     <= '0;
            bus_addr_q <= '0;
            bus_rd_q   <= 1'b0;
            ack_q      <= 1'b0;
            pf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            base_q     <= base_d;
            line_q     <= line_d;
            bus_addr_q <= bus_addr_d;
            bus_rd_q   <= bus_rd_d;
            ack_q      <= ack_d;
            pf_q       <= pf_d;
        end
    end

    // The line buffer is the output register, so data_o is stable for the whole ack cycle.
    assign data_o          = line_q;
    assign ack_o           = ack_q;
    assign hw_page_fault_o = pf_q;
    assign bus_addr_o      = bus_addr_q;
    assign bus_rd_o        = bus_rd_q;

endmodule

// File: tb/tb_inst_line_fetcher.sv
// Bench for inst_line_fetcher: table of directed fills, hand sequences for withdraw and
// mid-fill reset, then random fills checked against a transaction-level timing model.
module tb_inst_line_fetcher;

    localparam int LW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr_i;
    logic          rd_i;
    logic [255:0]  data_o;
    logic          ack_o;
    logic          hw_page_fault_o;
    logic [31:0]   bus_addr_o;
    logic          bus_rd_o;
    logic [31:0]   bus_data_i;
    logic          bus_ack_i;
    logic          bus_page_fault_i;

    int n_tests = 0;
    int n_fail  = 0;

    inst_line_fetcher #(
        .LINE_WORDS(LW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .addr_i          (addr_i),
        .rd_i            (rd_i),
        .data_o          (data_o),
        .ack_o           (ack_o),
        .hw_page_fault_o (hw_page_fault_o),
        .bus_addr_o      (bus_addr_o),
        .bus_rd_o        (bus_rd_o),
        .bus_data_i      (bus_data_i),
        .bus_ack_i       (bus_ack_i),
        .bus_page_fault_i(bus_page_fault_i)
    );

    always #5 clk = ~clk;

    typedef int waits_t [LW];

    typedef struct {
        logic [31:0] addr;
        int          w;      // uniform wait cycles per beat
        int          fb;     // faulting beat, -1 for none
        logic [31:0] dbase;
        int          ackc;   // expected ack_o cycle, counted from the request cycle
        logic        pf;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-transaction model: beat k is presented at cycle t, acked w[k] cycles later;
    // an ack needing TO or more waits never lands and ack_o follows TO+1 cycles after t.
    function automatic void model(input waits_t w, input int fb, input logic [31:0] dbase,
                                  output logic [255:0] line, output logic [255:0] mask,
                                  output logic pf, output int ackc);
        int t;
        t    = 1;
        line = '0;
        mask = '1;
        pf   = 1'b0;
        ackc = 0;
        for (int k = 0; k < LW; k++) begin
            if (w[k] >= TO) begin
                pf   = 1'b1;
                ackc = t + TO + 1;
                return;
            end
            t += w[k];
            line[32*k +: 32] = dbase + 32'(k);
            if (k == fb) begin
                // Content of the faulting word itself is not relied upon by the cache.
                mask[32*k +: 32] = '0;
                line[32*k +: 32] = '0;
                pf   = 1'b1;
                ackc = t + 1;
                return;
            end
            t += 1;
        end
        ackc = t;
    endfunction

    // Issues one request from the current cycle (cycle 0) and plays the bus slave.
    task automatic fill(input string tag, input logic [31:0] addr, input waits_t w,
                        input int fb, input logic [31:0] dbase, input int exp_ackc,
                        input logic exp_pf);
        logic [255:0] eline, emask;
        logic         epf;
        int           mackc;
        logic [31:0]  base;
        int           beat, wcnt, cyc;
        bit           seen, active;
        model(w, fb, dbase, eline, emask, epf, mackc);
        base      = addr & ~32'h1F;
        addr_i    = addr;
        rd_i      = 1'b1;
        bus_ack_i = 1'b0;
        beat      = 0;
        wcnt      = 0;
        cyc       = 0;
        seen      = 1'b0;
        active    = 1'b0;
        while (!seen && cyc <= exp_ackc + 2) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check({tag, " bus_rd rise"}, 256'(bus_rd_o), 256'(1));
                check({tag, " line cleared"}, data_o, '0);
            end
            if (ack_o) begin
                seen = 1'b1;
                rd_i = 1'b0;
                check({tag, " ack cycle"}, 256'(cyc), 256'(exp_ackc));
                check({tag, " line"}, data_o & emask, eline);
                check({tag, " page fault"}, 256'(hw_page_fault_o), 256'(exp_pf));
                check({tag, " bus_rd low at ack"}, 256'(bus_rd_o), '0);
            end
            bus_ack_i        = 1'b0;
            bus_data_i       = $urandom;
            bus_page_fault_i = 1'($urandom_range(0, 1));
            if (!active && !seen && bus_rd_o && beat < LW) begin
                active = 1'b1;
                wcnt   = 0;
            end
            if (active) begin
                if (bus_rd_o) begin
                    check({tag, " bus addr"}, 256'(bus_addr_o), 256'(base + 32'(4 * beat)));
                end
                if (wcnt == w[beat]) begin
                    bus_ack_i        = 1'b1;
                    bus_data_i       = dbase + 32'(beat);
                    bus_page_fault_i = (beat == fb);
                    active           = 1'b0;
                    beat             = (beat == fb) ? LW : beat + 1;
                end else begin
                    wcnt++;
                end
            end
        end
        if (!seen) begin
            check({tag, " ack_o seen"}, 256'(seen), 256'(1));
            rd_i = 1'b0;
        end
        tick();
        bus_ack_i = 1'b0;
        check({tag, " ack one cycle"}, 256'(ack_o), '0);
        check({tag, " pf cleared"}, 256'(hw_page_fault_o), '0);
        check({tag, " data held"}, data_o & emask, eline);
        check({tag, " bus_rd idle"}, 256'(bus_rd_o), '0);
    endtask

    initial begin
        waits_t w;
        logic [255:0] eline, emask;
        logic         epf;
        int           eackc;

        tbl[0] = '{32'h0000_1234, 0, -1, 32'h1000_0000, 9,  1'b0};
        tbl[1] = '{32'h0000_1234, 2, -1, 32'h1000_0000, 25, 1'b0};
        tbl[2] = '{32'h0000_1234, 0, 3,  32'h1000_0000, 5,  1'b1};
        tbl[3] = '{32'h0000_2000, 5, -1, 32'hA000_0000, 6,  1'b1};
        tbl[4] = '{32'hFFFF_FFE8, 1, 7,  32'h5555_0000, 17, 1'b1};
        tbl[5] = '{32'h8000_001F, 3, 0,  32'h0BAD_0000, 5,  1'b1};
        tbl[6] = '{32'h0000_0000, 3, -1, 32'h7700_0000, 33, 1'b0};

        rst              = 1'b1;
        rd_i             = 1'b0;
        addr_i           = 32'h0;
        bus_ack_i        = 1'b0;
        bus_data_i       = 32'h0;
        bus_page_fault_i = 1'b0;
        tick();
        tick();
        check("reset data_o", data_o, '0);
        check("reset ack_o", 256'(ack_o), '0);
        check("reset pf", 256'(hw_page_fault_o), '0);
        check("reset bus_addr", 256'(bus_addr_o), '0);
        check("reset bus_rd", 256'(bus_rd_o), '0);
        rst = 1'b0;
        tick();

        // Back-to-back: each fill's request goes up the cycle after the previous ack.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < LW; k++) w[k] = tbl[i].w;
            fill($sformatf("vec%0d", i), tbl[i].addr, w, tbl[i].fb, tbl[i].dbase,
                 tbl[i].ackc, tbl[i].pf);
        end

        // Request withdrawn while beat 0 is in flight: beat completes, no ack_o.
        tick();
        addr_i = 32'h0000_4000;
        rd_i   = 1'b1;
        tick();
        check("wd bus_rd c1", 256'(bus_rd_o), 256'(1));
        tick();
        rd_i = 1'b0;
        check("wd bus_rd c2", 256'(bus_rd_o), 256'(1));
        tick();
        check("wd bus_rd c3", 256'(bus_rd_o), 256'(1));
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hDEAD_BEEF;
        tick();
        bus_ack_i = 1'b0;
        check("wd bus_rd dropped", 256'(bus_rd_o), '0);
        for (int i = 0; i < 4; i++) begin
            check("wd no ack", 256'(ack_o), '0);
            tick();
        end

        // Reset after beat 4 of a zero-wait fill.
        addr_i = 32'h0000_3000;
        rd_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus_ack_i        = 1'b1;
            bus_data_i       = 32'hC000_0000 + 32'(i);
            bus_page_fault_i = 1'b0;
        end
        tick();
        check("rst beat5 addr", 256'(bus_addr_o), 256'(32'h0000_3014));
        bus_ack_i = 1'b0;
        rd_i      = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst data_o", data_o, '0);
        check("midrst ack_o", 256'(ack_o), '0);
        check("midrst bus_addr", 256'(bus_addr_o), '0);
        check("midrst bus_rd", 256'(bus_rd_o), '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst no ack", 256'(ack_o), '0);
        end
        for (int k = 0; k < LW; k++) w[k] = 0;
        fill("after rst", 32'h0000_3000, w, -1, 32'h1234_0000, 9, 1'b0);

        // Random fills against the model.
        for (int i = 0; i < 40; i++) begin
            int fb;
            logic [31:0] a, d;
            for (int k = 0; k < LW; k++) begin
                w[k] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(5, 6))
                                                    : int'($urandom_range(0, 3));
            end
            fb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            a  = $urandom;
            d  = $urandom;
            model(w, fb, d, eline, emask, epf, eackc);
            fill($sformatf("rnd%0d", i), a, w, fb, d, eackc, epf);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
